// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: default operand width and divider
// state encoding.
package arith_pkg;

   localparam int unsigned DEF_N = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
// Ports: rem/q   - current partial remainder (n+1 b) and quotient shift reg (n b)
//        B       - divisor (n b)
//        rem_next/q_next - values after shifting {rem,q} left and a trial subtract
module div_step
   import arith_pkg::*;
#(
   parameter int unsigned n = DEF_N
) (
   input  logic [n:0]   rem,
   input  logic [n-1:0] q,
   input  logic [n-1:0] B,
   output logic [n:0]   rem_next,
   output logic [n-1:0] q_next
);

   logic [n+1:0] rem_sh;
   logic [n:0]   trial;
   logic         fits;

   // Shift in the next dividend bit, then restore if the divisor does not fit.
   always_comb begin
      rem_sh = {rem, q[n-1]};
      fits   = (rem_sh >= (n+2)'(B));
      trial  = rem_sh[n:0] - {1'b0, B};
      if (fits) begin
         rem_next = trial;
         q_next   = {q[n-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[n:0];
         q_next   = {q[n-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sequential_divider.sv
// Iterative restoring divider: Z (2n b) / B (n b) -> Q, R (n b), one quotient
// bit per clock. Quotient overflow (including B == 0) is flagged at accept.
// Ports: clk, rst_n        - clock, async active-low reset
//        start, Z, B       - request and operands, sampled when not busy
//        busy, done        - iterating / one-cycle result-valid pulse
//        err, Q, R         - overflow flag, quotient, remainder
module sequential_divider
   import arith_pkg::*;
#(
   parameter int unsigned n = DEF_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*n-1:0] Z,
   input  logic [n-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [n-1:0]   Q,
   output logic [n-1:0]   R
);

   localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;

   div_state_t   state, state_next;
   logic [n-1:0] b_reg, b_next;
   logic [n:0]   rem, rem_next;
   logic [n-1:0] qsr, qsr_next;
   logic [CW-1:0] cnt, cnt_next;
   logic         err_next;
   logic [n-1:0] Q_next, R_next;
   logic [n:0]   step_rem;
   logic [n-1:0] step_q;
   logic         accept;

   div_step #(.n(n)) u_step (
      .rem      (rem),
      .q        (qsr),
      .B        (b_reg),
      .rem_next (step_rem),
      .q_next   (step_q)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         b_reg <= '0;
         rem   <= '0;
         qsr   <= '0;
         cnt   <= '0;
         err   <= 1'b0;
         Q     <= '0;
         R     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         b_reg <= b_next;
         rem   <= rem_next;
         qsr   <= qsr_next;
         cnt   <= cnt_next;
         err   <= err_next;
         Q     <= Q_next;
         R     <= R_next;
         busy  <= (state_next == S_RUN);
         done  <= (state_next == S_DONE);
      end
   end

   // Next-state and datapath update; an accept overrides the per-state update.
   always_comb begin
      state_next = state;
      b_next     = b_reg;
      rem_next   = rem;
      qsr_next   = qsr;
      cnt_next   = cnt;
      err_next   = err;
      Q_next     = Q;
      R_next     = R;
      accept     = start && (state != S_RUN);

      unique case (state)
         S_RUN: begin
            rem_next = step_rem;
            qsr_next = step_q;
            if (cnt == '0) begin
               state_next = S_DONE;
               Q_next     = step_q;
               R_next     = step_rem[n-1:0];
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      if (accept) begin
         b_next   = B;
         rem_next = {1'b0, Z[2*n-1:n]};
         qsr_next = Z[n-1:0];
         cnt_next = CW'(n - 1);
         // High half >= divisor means the quotient cannot fit in n bits.
         if (Z[2*n-1:n] >= B) begin
            state_next = S_DONE;
            err_next   = 1'b1;
            Q_next     = '1;
            R_next     = '0;
         end else begin
            state_next = S_RUN;
            err_next   = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_sequential_divider;

   localparam int unsigned N = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2*N-1:0] Z = '0;
   logic [N-1:0]  B = '0;
   logic          busy, done, err;
   logic [N-1:0]  Q, R;

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         e;
      int           due;
   } exp_t;

   exp_t sb[$];

   sequential_divider #(.n(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .Z     (Z),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .Q     (Q),
      .R     (R)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: plain integer division; overflow when quotient exceeds n bits.
   function automatic exp_t model(input logic [2*N-1:0] z, input logic [N-1:0] b, input int e);
      exp_t x;
      longint unsigned zz, bb, qq;
      zz = longint'(z);
      bb = longint'(b);
      if (bb == 0 || zz / bb >= (64'd1 << N)) begin
         x.q = '1; x.r = '0; x.e = 1'b1; x.due = e;
      end else begin
         qq = zz / bb;
         x.q = N'(qq); x.r = N'(zz % bb); x.e = 1'b0; x.due = e + N;
      end
      return x;
   endfunction

   // Monitor: compare on every done pulse, and flag results that never arrive.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", longint'(done), 0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("Q", longint'(Q), longint'(x.q));
               chk("R", longint'(R), longint'(x.r));
               chk("err", longint'(err), longint'(x.e));
               chk("done_cycle", cyc, x.due);
               chk("busy_at_done", longint'(busy), 0);
            end
         end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("late_done", cyc, sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   task automatic wait_free();
      int t;
      t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("wait_free_timeout", t, 0);
   endtask

   // Issue one request at a negedge; the following posedge accepts it.
   task automatic issue(input logic [2*N-1:0] z, input logic [N-1:0] b);
      wait_free();
      start = 1'b1; Z = z; B = b;
      sb.push_back(model(z, b, cyc + 1));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle_until_empty();
      int t;
      t = 0;
      while (sb.size() > 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      logic [2*N-1:0] z;
      logic [N-1:0]   b, a;
      int             e1;

      #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_Q", longint'(Q), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases, including exact, remainder, boundary and overflow.
      issue(32'd4500, 16'd150);
      issue(32'd880, 16'd8);
      issue(32'd1024, 16'd2);
      issue(32'd4507, 16'd150);
      issue(32'hFFFE0001, 16'hFFFF);
      idle_until_empty();
      issue(32'd1234, 16'd0);
      chk("err_no_busy", longint'(busy), 0);
      issue(32'h00010000, 16'd1);
      chk("err_no_busy2", longint'(busy), 0);
      idle_until_empty();

      // start mid-run with other operands must be ignored.
      issue(32'd99999, 16'd77);
      repeat (3) @(negedge clk);
      start = 1'b1; Z = 32'd5; B = 16'd1;
      @(negedge clk);
      start = 1'b0;
      idle_until_empty();

      // Back-to-back: start held high through the DONE cycle.
      wait_free();
      start = 1'b1; Z = 32'd70000; B = 16'd300;
      e1 = cyc + 1;
      sb.push_back(model(32'd70000, 16'd300, e1));
      @(negedge clk);
      Z = 32'h00123456; B = 16'h0ABC;
      sb.push_back(model(32'h00123456, 16'h0ABC, e1 + N + 1));
      repeat (N) @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      idle_until_empty();

      // Reset mid-run clears outputs and drops the pending result.
      issue(32'd4507, 16'd150);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_done", longint'(done), 0);
      chk("midrst_err", longint'(err), 0);
      chk("midrst_Q", longint'(Q), 0);
      chk("midrst_R", longint'(R), 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * N) @(negedge clk);
      chk("post_rst_busy", longint'(busy), 0);

      // Round trip through a multiplier: (A*B)/B == A, remainder 0.
      for (int i = 0; i < 10; i++) begin
         exp_t x;
         a = N'($urandom);
         b = N'($urandom_range(1, (1 << N) - 1));
         z = (2*N)'(a) * (2*N)'(b);
         wait_free();
         start = 1'b1; Z = z; B = b;
         x.q = a; x.r = '0; x.e = 1'b0; x.due = cyc + 1 + N;
         sb.push_back(x);
         @(negedge clk);
         start = 1'b0;
      end
      idle_until_empty();

      // Randomized operands, mostly non-overflowing.
      for (int i = 0; i < 40; i++) begin
         b = N'($urandom);
         if (($urandom % 8) == 0) b = '0;
         z = (2*N)'($urandom);
         if (b != 0 && ($urandom % 4) != 0)
            z[2*N-1:N] = N'($urandom % b);
         issue(z, b);
         if (($urandom % 3) == 0) idle_until_empty();
      end
      idle_until_empty();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
